pipeline_hazard_ctrl: RTL and testbench

//  Sequences the 5-stage pipeline around the instruction decoder's control outputs.
//  - Tracks destination-register state of the EX and MEM stages.
//  - Generates operand/flag forwarding selects and load-use stalls.
//  - Squashes the IF/ID register on branches taken in ID.
//  - Keeps saturating stall/flush performance counters.

---
 rtl/pipe_ctrl_pkg.sv | 22 ++
 rtl/hazard_stage_reg.sv | 23 ++
 rtl/pipeline_hazard_ctrl.sv | 126 ++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the pipeline hazard controller:
// forwarding selects and the per-stage destination shadow.
package pipe_ctrl_pkg;

    localparam int RD_W     = 5;
    localparam int ZERO_REG = 31;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_EX  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef struct packed {
        logic            v;
        logic [RD_W-1:0] rd;
        logic            wr;
        logic            mrd;
        logic            fs;
    } stage_info_t;

endpackage

// File: rtl/hazard_stage_reg.sv
// Destination-shadow register for one pipeline stage;
// bubble loads an empty (v=0) record.
module hazard_stage_reg
    import pipe_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        bubble,
    input  stage_info_t d,
    output stage_info_t q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q <= '0;
        end else if (bubble) begin
            q <= '0;
        end else begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Load-use stall, operand/flag forwarding and branch squash
// control for the 5-stage pipeline, plus stall/flush counters.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = pipe_ctrl_pkg::ZERO_REG,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic             id_use_rd,
    input  logic             id_reg_write,
    input  logic             id_mem_read,
    input  logic             id_flag_set,
    input  logic             id_flag_use,
    input  logic             id_br_taken,
    output logic             stall,
    output logic             bubble,
    output logic             flush_if,
    output fwd_sel_t         fwd_a,
    output fwd_sel_t         fwd_b,
    output fwd_sel_t         fwd_d,
    output logic             flag_fwd,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    stage_info_t id_info;
    stage_info_t ex_q;
    stage_info_t mem_q;
    logic        ex_bubble;
    logic        lu_a;
    logic        lu_b;
    logic        lu_d;

    function automatic logic hit(
        input logic [REG_W-1:0] s,
        input stage_info_t      st
    );
        return st.v && st.wr &&
               (st.rd == RD_W'(s)) &&
               (s != REG_W'(ZERO_REG));
    endfunction

    function automatic fwd_sel_t fwd_sel(
        input logic             vld,
        input logic             use_s,
        input logic [REG_W-1:0] s,
        input stage_info_t      ex,
        input stage_info_t      mem
    );
        fwd_sel_t sel;
        sel = FWD_REG;
        if (vld && use_s) begin
            if (hit(s, ex) && !ex.mrd) begin
                sel = FWD_EX;
            end else if (hit(s, mem)) begin
                sel = FWD_MEM;
            end
        end
        return sel;
    endfunction

    always_comb begin
        id_info     = '0;
        id_info.v   = id_valid;
        id_info.rd  = RD_W'(id_rd);
        id_info.wr  = id_reg_write;
        id_info.mrd = id_mem_read;
        id_info.fs  = id_flag_set;
    end

    assign ex_bubble = !id_valid || stall;

    hazard_stage_reg u_ex_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .bubble  (ex_bubble),
        .d       (id_info),
        .q       (ex_q)
    );

    hazard_stage_reg u_mem_reg (
        .clk     (clk),
        .reset_n (reset_n),
        .bubble  (1'b0),
        .d       (ex_q),
        .q       (mem_q)
    );

    // A load still in EX has no data yet: stall one cycle, then MEM forwards
    assign lu_a = id_use_rn && hit(id_rn, ex_q) && ex_q.mrd;
    assign lu_b = id_use_rm && hit(id_rm, ex_q) && ex_q.mrd;
    assign lu_d = id_use_rd && hit(id_rd, ex_q) && ex_q.mrd;

    assign stall    = id_valid && (lu_a || lu_b || lu_d);
    assign bubble   = stall;
    assign flush_if = id_valid && id_br_taken && !stall;
    assign flag_fwd = id_valid && id_flag_use && ex_q.v && ex_q.fs;

    assign fwd_a = fwd_sel(id_valid, id_use_rn, id_rn, ex_q, mem_q);
    assign fwd_b = fwd_sel(id_valid, id_use_rm, id_rm, ex_q, mem_q);
    assign fwd_d = fwd_sel(id_valid, id_use_rd, id_rd, ex_q, mem_q);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && !(&stall_cnt)) begin
                stall_cnt <= stall_cnt + CNT_W'(1);
            end
            if (flush_if && !(&flush_cnt)) begin
                flush_cnt <= flush_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl: forwarding/stall vectors
// plus counter, reset and saturation sequences.
module tb_pipeline_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    logic       clk;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic [4:0] id_rd;
    logic       id_use_rn;
    logic       id_use_rm;
    logic       id_use_rd;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       id_flag_set;
    logic       id_flag_use;
    logic       id_br_taken;

    logic        stall, bubble, flush_if, flag_fwd;
    fwd_sel_t    fwd_a, fwd_b, fwd_d;
    logic [31:0] stall_cnt, flush_cnt;

    logic        s_stall, s_bubble, s_flush_if, s_flag_fwd;
    fwd_sel_t    s_fwd_a, s_fwd_b, s_fwd_d;
    logic [1:0]  s_stall_cnt, s_flush_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    pipeline_hazard_ctrl u_dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_rd        (id_rd),
        .id_use_rn    (id_use_rn),
        .id_use_rm    (id_use_rm),
        .id_use_rd    (id_use_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_flag_set  (id_flag_set),
        .id_flag_use  (id_flag_use),
        .id_br_taken  (id_br_taken),
        .stall        (stall),
        .bubble       (bubble),
        .flush_if     (flush_if),
        .fwd_a        (fwd_a),
        .fwd_b        (fwd_b),
        .fwd_d        (fwd_d),
        .flag_fwd     (flag_fwd),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    pipeline_hazard_ctrl #(.CNT_W(2)) u_sat (
        .clk          (clk),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .id_rn        (id_rn),
        .id_rm        (id_rm),
        .id_rd        (id_rd),
        .id_use_rn    (id_use_rn),
        .id_use_rm    (id_use_rm),
        .id_use_rd    (id_use_rd),
        .id_reg_write (id_reg_write),
        .id_mem_read  (id_mem_read),
        .id_flag_set  (id_flag_set),
        .id_flag_use  (id_flag_use),
        .id_br_taken  (id_br_taken),
        .stall        (s_stall),
        .bubble       (s_bubble),
        .flush_if     (s_flush_if),
        .fwd_a        (s_fwd_a),
        .fwd_b        (s_fwd_b),
        .fwd_d        (s_fwd_d),
        .flag_fwd     (s_flag_fwd),
        .stall_cnt    (s_stall_cnt),
        .flush_cnt    (s_flush_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // {v,rd,wr,mrd,fs}
    function automatic logic [8:0] pre(
        input logic v, input logic [4:0] rd,
        input logic wr, input logic mrd, input logic fs
    );
        return {v, rd, wr, mrd, fs};
    endfunction

    // {v,rn,rm,rd,urn,urm,urd,wr,mr,fs,fu,br}
    function automatic logic [24:0] idw(
        input logic v, input logic [4:0] rn,
        input logic [4:0] rm, input logic [4:0] rd,
        input logic urn, input logic urm, input logic urd,
        input logic wr, input logic mr, input logic fs,
        input logic fu, input logic br
    );
        return {v, rn, rm, rd, urn, urm, urd, wr, mr, fs, fu, br};
    endfunction

    // {stall,bubble,flush_if,fwd_a,fwd_b,fwd_d,flag_fwd}
    function automatic logic [9:0] ex(
        input logic s, input logic b, input logic f,
        input fwd_sel_t a, input fwd_sel_t bb,
        input fwd_sel_t d, input logic ff
    );
        return {s, b, f, a, bb, d, ff};
    endfunction

    typedef struct {
        string       name;
        logic [8:0]  mem_i;
        logic [8:0]  ex_i;
        logic [24:0] id_i;
        logic [9:0]  exp;
    } vec_t;

    vec_t vecs[13];

    task automatic drive_id(input logic [24:0] w);
        {id_valid, id_rn, id_rm, id_rd,
         id_use_rn, id_use_rm, id_use_rd,
         id_reg_write, id_mem_read, id_flag_set,
         id_flag_use, id_br_taken} = w;
    endtask

    task automatic drive_pre(input logic [8:0] p);
        drive_id({p[8], 5'd0, 5'd0, p[7:3], 3'b000,
                  p[2], p[1], p[0], 2'b00});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", nm, got, req);
        end
    endtask

    function automatic logic [9:0] outs();
        return {stall, bubble, flush_if, fwd_a, fwd_b, fwd_d, flag_fwd};
    endfunction

    logic [9:0] idle_exp;

    initial begin
        idle_exp = ex(1'b0, 1'b0, 1'b0, FWD_REG, FWD_REG, FWD_REG, 1'b0);

        vecs[0]  = '{"ldur_use_rn", pre(0,0,0,0,0), pre(1,2,1,1,0),
                     idw(1,2,4,3,1,1,0,1,0,1,0,0),
                     ex(1,1,0,FWD_REG,FWD_REG,FWD_REG,0)};
        vecs[1]  = '{"ex_over_mem", pre(1,5,1,0,0), pre(1,5,1,0,0),
                     idw(1,5,0,6,1,0,0,1,0,0,0,0),
                     ex(0,0,0,FWD_EX,FWD_REG,FWD_REG,0)};
        vecs[2]  = '{"ldur_x31", pre(0,0,0,0,0), pre(1,31,1,1,0),
                     idw(1,31,0,6,1,0,0,1,0,0,0,0),
                     ex(0,0,0,FWD_REG,FWD_REG,FWD_REG,0)};
        vecs[3]  = '{"subs_blt", pre(0,0,0,0,0), pre(1,1,1,0,1),
                     idw(1,0,0,0,0,0,0,0,0,0,1,1),
                     ex(0,0,1,FWD_REG,FWD_REG,FWD_REG,1)};
        vecs[4]  = '{"stur_fwd_d_mem", pre(1,7,1,1,0), pre(0,0,0,0,0),
                     idw(1,1,0,7,1,0,1,0,0,0,0,0),
                     ex(0,0,0,FWD_REG,FWD_REG,FWD_MEM,0)};
        vecs[5]  = '{"a_mem_b_ex", pre(1,8,1,0,0), pre(1,9,1,0,0),
                     idw(1,8,9,10,1,1,0,1,0,0,0,0),
                     ex(0,0,0,FWD_MEM,FWD_EX,FWD_REG,0)};
        vecs[6]  = '{"id_invalid", pre(0,0,0,0,0), pre(1,2,1,1,1),
                     idw(0,2,2,2,1,1,1,1,0,0,1,1),
                     ex(0,0,0,FWD_REG,FWD_REG,FWD_REG,0)};
        vecs[7]  = '{"ex_no_write", pre(0,0,0,0,0), pre(1,3,0,0,0),
                     idw(1,3,0,6,1,0,0,1,0,0,0,0),
                     ex(0,0,0,FWD_REG,FWD_REG,FWD_REG,0)};
        vecs[8]  = '{"cbz_ldur_stall", pre(0,0,0,0,0), pre(1,4,1,1,0),
                     idw(1,0,0,4,0,0,1,0,0,0,0,1),
                     ex(1,1,0,FWD_REG,FWD_REG,FWD_REG,0)};
        vecs[9]  = '{"fs_no_use", pre(0,0,0,0,0), pre(1,6,1,0,1),
                     idw(1,1,6,7,1,1,0,1,0,0,0,0),
                     ex(0,0,0,FWD_REG,FWD_EX,FWD_REG,0)};
        vecs[10] = '{"mem_x31", pre(1,31,1,0,0), pre(0,0,0,0,0),
                     idw(1,31,0,6,1,0,0,1,0,0,0,0),
                     ex(0,0,0,FWD_REG,FWD_REG,FWD_REG,0)};
        vecs[11] = '{"mem_ldur_rm", pre(1,10,1,1,0), pre(0,0,0,0,0),
                     idw(1,1,10,6,0,1,0,1,0,0,0,0),
                     ex(0,0,0,FWD_REG,FWD_MEM,FWD_REG,0)};
        vecs[12] = '{"unused_src", pre(0,0,0,0,0), pre(1,5,1,1,0),
                     idw(1,5,5,5,0,0,0,1,0,0,0,0),
                     ex(0,0,0,FWD_REG,FWD_REG,FWD_REG,0)};

        reset_n = 1'b0;
        drive_id('0);
        #1;
        chk("reset_outs", {22'd0, outs()}, {22'd0, idle_exp});
        chk("reset_stall_cnt", stall_cnt, 32'd0);
        chk("reset_flush_cnt", flush_cnt, 32'd0);
        step();
        step();
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            drive_pre(vecs[i].mem_i);
            step();
            drive_pre(vecs[i].ex_i);
            step();
            drive_id(vecs[i].id_i);
            #1;
            chk(vecs[i].name, {22'd0, outs()}, {22'd0, vecs[i].exp});
        end

        // load-use, then flag branch, then CBZ held by load-use
        reset_n = 1'b0;
        drive_id('0);
        step();
        reset_n = 1'b1;
        drive_pre(pre(1,2,1,1,0));
        step();
        drive_id(idw(1,2,4,3,1,1,0,1,0,1,0,0));
        #1;
        chk("lu_stall", {22'd0, outs()},
            {22'd0, ex(1,1,0,FWD_REG,FWD_REG,FWD_REG,0)});
        chk("lu_cnt0", stall_cnt, 32'd0);
        step();
        chk("lu_resolve", {22'd0, outs()},
            {22'd0, ex(0,0,0,FWD_MEM,FWD_REG,FWD_REG,0)});
        chk("lu_cnt1", stall_cnt, 32'd1);
        step();
        drive_id(idw(1,0,0,0,0,0,0,0,0,0,1,1));
        #1;
        chk("blt_flush", {22'd0, outs()},
            {22'd0, ex(0,0,1,FWD_REG,FWD_REG,FWD_REG,1)});
        step();
        chk("flush_cnt1", flush_cnt, 32'd1);
        drive_pre(pre(1,4,1,1,0));
        step();
        drive_id(idw(1,0,0,4,0,0,1,0,0,0,0,1));
        #1;
        chk("cbz_held", {22'd0, outs()},
            {22'd0, ex(1,1,0,FWD_REG,FWD_REG,FWD_REG,0)});
        step();
        chk("cbz_go", {22'd0, outs()},
            {22'd0, ex(0,0,1,FWD_REG,FWD_REG,FWD_MEM,0)});
        step();
        chk("stall_cnt2", stall_cnt, 32'd2);
        chk("flush_cnt2", flush_cnt, 32'd2);

        // reset while stalled
        drive_pre(pre(1,2,1,1,0));
        step();
        drive_id(idw(1,2,4,3,1,1,0,1,0,1,0,0));
        #1;
        chk("pre_rst_stall", {31'd0, stall}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_mid_outs", {22'd0, outs()}, {22'd0, idle_exp});
        chk("rst_mid_stall_cnt", stall_cnt, 32'd0);
        chk("rst_mid_flush_cnt", flush_cnt, 32'd0);
        step();
        reset_n = 1'b1;
        #1;
        chk("post_rst_fwd", {22'd0, outs()}, {22'd0, idle_exp});

        // five load-use stalls: 2-bit counter pins at 3
        for (int k = 0; k < 5; k++) begin
            drive_pre(pre(1,2,1,1,0));
            step();
            drive_id(idw(1,2,4,3,1,1,0,1,0,1,0,0));
            step();
            step();
        end
        chk("sat_stall_cnt", {30'd0, s_stall_cnt}, 32'd3);
        chk("full_stall_cnt", stall_cnt, 32'd5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
